// File: rtl/exception_vector_sequencer.sv
// Exception vector sequencer: records EPC/Cause, fetches the handler byte from the
// fixed vector address and loads it into the PC while the main control is stalled.
module exception_vector_sequencer #(
  parameter int unsigned VEC_OPCODE = 253,
  parameter int unsigned VEC_OVF    = 254,
  parameter int unsigned VEC_DIV0   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_req,
  input  logic [31:0] exc_cause,
  input  logic [31:0] pc_current,
  output logic        exc_busy,
  output logic        epc_we,
  output logic [31:0] epc_out,
  output logic        cause_we,
  output logic [31:0] cause_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        exc_done,
  output logic        exc_invalid
);

  typedef enum logic [2:0] {IDLE, DECODE, SAVE, FETCH, LOAD} state_t;

  state_t      state, state_next;
  logic [31:0] cause_r, epc_r, vec_r, epc_q, cause_q;
  logic [7:0]  rdata_r;
  logic        cause_valid;
  logic [31:0] vec_sel;

  // The whole 32-bit cause is compared, so stray upper bits make it invalid
  always_comb begin
    cause_valid = 1'b1;
    vec_sel     = '0;
    case (cause_r)
      32'd1:   vec_sel = VEC_OPCODE;
      32'd2:   vec_sel = VEC_OVF;
      32'd3:   vec_sel = VEC_DIV0;
      default: cause_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    exc_busy    = 1'b1;
    epc_we      = 1'b0;
    cause_we    = 1'b0;
    mem_req     = 1'b0;
    pc_load     = 1'b0;
    exc_done    = 1'b0;
    exc_invalid = 1'b0;
    case (state)
      IDLE: begin
        exc_busy = 1'b0;
        if (exc_req) state_next = DECODE;
      end
      DECODE: begin
        if (cause_valid) begin
          state_next = SAVE;
        end else begin
          exc_invalid = 1'b1;
          state_next  = IDLE;
        end
      end
      SAVE: begin
        epc_we     = 1'b1;
        cause_we   = 1'b1;
        state_next = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = LOAD;
      end
      LOAD: begin
        pc_load    = 1'b1;
        exc_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write-data registers only move when their strobe is about to fire, so they hold between exceptions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_r <= '0;
      epc_r   <= '0;
      vec_r   <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      rdata_r <= '0;
    end else begin
      if (state == IDLE && exc_req) begin
        cause_r <= exc_cause;
        epc_r   <= pc_current - 32'd4;
      end
      if (state == DECODE && cause_valid) begin
        vec_r   <= vec_sel;
        epc_q   <= epc_r;
        cause_q <= cause_r;
      end
      if (state == FETCH && mem_ack) rdata_r <= mem_rdata;
    end
  end

  assign epc_out   = epc_q;
  assign cause_out = cause_q;
  assign mem_addr  = vec_r;
  assign pc_out    = {24'd0, rdata_r};

endmodule

// File: tb/tb_exception_vector_sequencer.sv
// Scoreboard bench for exception_vector_sequencer: expected EPC/Cause/vector/PC per
// request are queued at stimulus time and checked as the DUT strobes them.
module tb_exception_vector_sequencer;

  typedef struct {
    logic        invalid;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] addr;
    logic [31:0] pc;
    int          e0;
    int          lat;
    int          delay;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        exc_req = 1'b0;
  logic [31:0] exc_cause = '0;
  logic [31:0] pc_current = '0;
  logic        exc_busy, epc_we, cause_we, mem_req, pc_load, exc_done, exc_invalid;
  logic [31:0] epc_out, cause_out, mem_addr, pc_out;
  logic        resp_ack;
  logic        stray_ack = 1'b0;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  vmem [0:255];
  int          ack_delay = 0;
  int          fc;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          n_epc, n_cause, n_req;
  exp_t        exp_q[$];

  assign mem_ack = resp_ack | stray_ack;

  exception_vector_sequencer dut (
    .clk(clk), .reset_n(reset_n), .exc_req(exc_req), .exc_cause(exc_cause),
    .pc_current(pc_current), .exc_busy(exc_busy), .epc_we(epc_we), .epc_out(epc_out),
    .cause_we(cause_we), .cause_out(cause_out), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc_load(pc_load), .pc_out(pc_out),
    .exc_done(exc_done), .exc_invalid(exc_invalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Memory responder: acks after ack_delay FETCH cycles with the byte at mem_addr
  always @(negedge clk) begin
    if (!reset_n) begin
      resp_ack = 1'b0;
      fc = 0;
    end else if (mem_req) begin
      resp_ack  = (fc == ack_delay);
      mem_rdata = vmem[mem_addr[7:0]];
      fc++;
    end else begin
      resp_ack = 1'b0;
      fc = 0;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t cur;
    if (!reset_n) begin
      n_epc = 0; n_cause = 0; n_req = 0;
    end else if (exp_q.size() == 0) begin
      checkOutput("idle_strobes", {26'd0, epc_we, cause_we, mem_req, pc_load, exc_done, exc_invalid}, 32'd0);
      checkOutput("idle_busy", {31'd0, exc_busy}, 32'd0);
    end else begin
      cur = exp_q[0];
      if (cur.invalid)
        checkOutput("strobe_on_invalid", {28'd0, epc_we, cause_we, mem_req, pc_load}, 32'd0);
      if (epc_we) begin
        n_epc++;
        checkOutput("epc_out", epc_out, cur.epc);
        checkOutput("cause_out", cause_out, cur.cause);
        checkOutput("cause_we_with_epc", {31'd0, cause_we}, 32'd1);
        checkOutput("save_latency", cyc - cur.e0 + 1, 32'd2);
      end
      if (cause_we) n_cause++;
      if (mem_req) begin
        n_req++;
        checkOutput("mem_addr", mem_addr, cur.addr);
      end
      if (exc_invalid) begin
        checkOutput("invalid_expected", {31'd0, cur.invalid}, 32'd1);
        checkOutput("invalid_latency", cyc - cur.e0 + 1, 32'd1);
        void'(exp_q.pop_front());
        n_epc = 0; n_cause = 0; n_req = 0;
      end else if (pc_load) begin
        checkOutput("pc_out", pc_out, cur.pc);
        checkOutput("exc_done", {31'd0, exc_done}, 32'd1);
        checkOutput("load_latency", cyc - cur.e0 + 1, cur.lat);
        checkOutput("epc_we_count", n_epc, 32'd1);
        checkOutput("cause_we_count", n_cause, 32'd1);
        checkOutput("mem_req_cycles", n_req, cur.delay + 1);
        checkOutput("epc_hold", epc_out, cur.epc);
        checkOutput("cause_hold", cause_out, cur.cause);
        void'(exp_q.pop_front());
        n_epc = 0; n_cause = 0; n_req = 0;
      end else if (!exc_done) begin
        checkOutput("busy_in_sequence", {31'd0, exc_busy}, {31'd0, (cyc >= cur.e0)});
      end
    end
  end

  task automatic buildExp(input logic [31:0] cause, input logic [31:0] pc, input int delay,
                          input logic [7:0] rdata, input int e0, output exp_t e);
    e.invalid = !(cause inside {32'd1, 32'd2, 32'd3});
    e.epc     = pc - 32'd4;
    e.cause   = cause;
    e.addr    = (cause == 32'd1) ? 32'd253 : (cause == 32'd2) ? 32'd254 : 32'd255;
    e.pc      = {24'd0, rdata};
    e.e0      = e0;
    e.lat     = 4 + delay;
    e.delay   = delay;
    if (!e.invalid) vmem[e.addr[7:0]] = rdata;
  endtask

  // Called at a negedge with the DUT idle; returns at the DECODE-cycle negedge
  task automatic applyStimulus(input logic [31:0] cause, input logic [31:0] pc,
                               input int delay, input logic [7:0] rdata);
    exp_t e;
    buildExp(cause, pc, delay, rdata, cyc + 1, e);
    ack_delay = delay;
    exp_q.push_back(e);
    exc_cause  = cause;
    pc_current = pc;
    exc_req    = 1'b1;
    @(negedge clk);
    exc_req = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((exp_q.size() != 0 || exc_busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checkOutput("wait_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_strobes"}, {25'd0, exc_busy, epc_we, cause_we, mem_req, pc_load, exc_done, exc_invalid}, 32'd0);
    checkOutput({tag, "_epc_out"}, epc_out, 32'd0);
    checkOutput({tag, "_cause_out"}, cause_out, 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_pc_out"}, pc_out, 32'd0);
  endtask

  initial begin
    logic [31:0] bad_causes [3];
    exp_t e;
    int n;
    bad_causes = '{32'd0, 32'd4, 32'h0000_0101};
    for (int i = 0; i < 256; i++) vmem[i] = 8'h00;

    #1 reset_n = 1'b0;
    #1 checkResetOutputs("reset_init");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset while waiting for a slow memory ack
    applyStimulus(32'd2, 32'h100, 20, 8'h55);
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    checkOutput("reach_fetch", {31'd0, mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1 checkResetOutputs("reset_mid_fetch");
    exp_q.delete();
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(32'd2, 32'h40, 0, 8'h11);
    waitIdle();

    // Overflow, ack in first FETCH cycle
    applyStimulus(32'd2, 32'h100, 0, 8'h7A);
    waitIdle();

    // Invalid opcode, ack delayed by 3 cycles
    applyStimulus(32'd1, 32'h2000, 3, 8'hFF);
    waitIdle();

    // Unsupported cause codes
    for (int i = 0; i < 3; i++) begin
      applyStimulus(bad_causes[i], 32'h80, 0, 8'h00);
      checkOutput("inv_busy_decode", {31'd0, exc_busy}, 32'd1);
      @(negedge clk);
      checkOutput("inv_busy_after", {31'd0, exc_busy}, 32'd0);
      waitIdle();
    end

    // EPC wrap; exc_req and a stray ack during SAVE are ignored
    applyStimulus(32'd3, 32'h0, 1, 8'hC3);
    @(negedge clk);
    checkOutput("save_cycle", {31'd0, epc_we}, 32'd1);
    exc_req   = 1'b1;
    stray_ack = 1'b1;
    @(negedge clk);
    exc_req   = 1'b0;
    stray_ack = 1'b0;
    waitIdle();

    // Back-to-back: request held through LOAD is re-sampled in the following IDLE
    buildExp(32'd1, 32'h200, 0, 8'h33, cyc + 1, e);
    ack_delay = 0;
    exp_q.push_back(e);
    exc_cause  = 32'd1;
    pc_current = 32'h200;
    exc_req    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!pc_load && n < 50);
    checkOutput("b2b_first_load", {31'd0, pc_load}, 32'd1);
    buildExp(32'd3, 32'h300, 0, 8'h44, cyc + 2, e);
    exp_q.push_back(e);
    exc_cause  = 32'd3;
    pc_current = 32'h300;
    @(negedge clk);
    checkOutput("b2b_idle_gap", {31'd0, exc_busy}, 32'd0);
    @(negedge clk);
    exc_req = 1'b0;
    checkOutput("b2b_second_busy", {31'd0, exc_busy}, 32'd1);
    waitIdle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
